// File: rtl/axi_lsu_read_slave.sv
// axi_lsu_read_slave: single-outstanding AXI-style read responder with a programmable memory wait
module axi_lsu_read_slave #(
   parameter int                ADDR_W   = 64,
   parameter int                DATA_W   = 64,
   parameter int                LATENCY  = 2,
   parameter logic [ADDR_W-1:0] MEM_BASE = ADDR_W'(64'h8000_0000),
   parameter logic [ADDR_W-1:0] MEM_SIZE = ADDR_W'(64'h0800_0000)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] lsu_ar_addr,
   input  logic              lsu_ar_valid,
   output logic              lsu_ar_ready,
   output logic [DATA_W-1:0] lsu_r_data,
   output logic [1:0]        lsu_r_resp,
   output logic              lsu_r_valid,
   input  logic              lsu_r_ready,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [DATA_W-1:0] mem_rd_data
);
   localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
   localparam logic [ADDR_W:0] LO = {1'b0, MEM_BASE};
   localparam logic [ADDR_W:0] HI = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE} - (ADDR_W+1)'(8);
   localparam logic [3:0] LAT = 4'(LATENCY);
   logic [1:0] state;
   logic [3:0] cnt;
   logic       legal;
   if (LATENCY < 1 || LATENCY > 15) begin : g_lat_check
      $error("axi_lsu_read_slave: LATENCY %0d outside 1..15", LATENCY);
   end
   assign lsu_ar_ready = (state == IDLE) & ~rst;
   assign legal = (lsu_ar_addr[2:0] == 3'b000) && ({1'b0, lsu_ar_addr} >= LO) && ({1'b0, lsu_ar_addr} <= HI);
   // request/wait/response sequencing; the read strobe is a single-cycle pulse on WAIT entry
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         lsu_r_valid <= 1'b0;
         lsu_r_data  <= '0;
         lsu_r_resp  <= 2'b00;
         mem_rd_en   <= 1'b0;
         mem_rd_addr <= '0;
      end else begin
         mem_rd_en <= 1'b0;
         case (state)
            IDLE: if (lsu_ar_valid) begin
               if (legal) begin
                  state       <= WAIT;
                  cnt         <= 4'd1;
                  mem_rd_en   <= 1'b1;
                  mem_rd_addr <= lsu_ar_addr;
               end else begin
                  state       <= RESP;
                  lsu_r_valid <= 1'b1;
                  lsu_r_resp  <= 2'b10;
                  lsu_r_data  <= '0;
               end
            end
            WAIT: if (cnt == LAT) begin
               state       <= RESP;
               lsu_r_valid <= 1'b1;
               lsu_r_resp  <= 2'b00;
               lsu_r_data  <= mem_rd_data;
            end else begin
               cnt <= cnt + 4'd1;
            end
            RESP: if (lsu_r_ready) begin
               state       <= IDLE;
               lsu_r_valid <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
